// File: rtl/moore_seq_detector_param_pkg.sv
// Shared types and helpers for the parametrised Moore sequence detector.
// FSM encodings live here so every lab block decodes the state the same way.
package moore_seq_detector_param_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam int unsigned DEF_PAT_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 8;

  // Fill counter must hold 0..pat_len inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/moore_seq_detector_param_if.sv
// Serial-input / status-output bundle of the sequence detector.
interface moore_seq_detector_param_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             w;
  logic             clr_cnt;
  logic             z;
  logic             z_a;
  logic             z_b;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, w, clr_cnt,
    input  z, z_a, z_b, match_cnt, cnt_sat
  );

  modport slave (
    input  en, w, clr_cnt,
    output z, z_a, z_b, match_cnt, cnt_sat
  );
endinterface

// File: rtl/moore_seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);
  logic [W-1:0] r_cnt;
  logic         r_sat;
  logic [W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (inc && !r_sat) begin
      w_cnt_nxt = r_cnt + W'(1);
    end
  end

  // Saturation flag tracks the next count so it lines up with cnt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= &w_cnt_nxt;
    end
  end

  assign cnt = r_cnt;
  assign sat = r_sat;
endmodule

// File: rtl/moore_seq_detector_param.sv
// Moore serial detector for two programmable patterns with optional overlap
// and a saturating match counter.
module moore_seq_detector_param
  import moore_seq_detector_param_pkg::*;
#(
  parameter int unsigned       PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PAT_A  = PAT_LEN'(4'b1111),
  parameter logic [PAT_LEN-1:0] PAT_B  = PAT_LEN'(4'b1001),
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       CNT_W   = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  moore_seq_detector_param_if.slave   bus
);
  localparam int unsigned FILL_W = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [PAT_LEN-1:0]  r_hist;
  logic [PAT_LEN-1:0]  w_hist_nxt;
  logic [FILL_W-1:0]   r_fill;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic                r_z_a;
  logic                r_z_b;
  logic                r_z;
  logic                w_z_a_nxt;
  logic                w_z_b_nxt;
  logic                w_match_a;
  logic                w_match_b;
  logic                w_inc;
  logic                w_full;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_FILL;
      r_hist  <= '0;
      r_fill  <= '0;
      r_z_a   <= 1'b0;
      r_z_b   <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_z_a   <= w_z_a_nxt;
      r_z_b   <= w_z_b_nxt;
      r_z     <= w_z_a_nxt | w_z_b_nxt;
    end
  end

  // Matches are judged on the post-shift history and post-increment fill.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_z_a_nxt   = r_z_a;
    w_z_b_nxt   = r_z_b;
    w_match_a   = 1'b0;
    w_match_b   = 1'b0;
    w_inc       = 1'b0;
    w_full      = 1'b0;

    if (r_fill > FILL_FULL) begin
      w_fill_nxt  = '0;
      w_state_nxt = ST_FILL;
      w_z_a_nxt   = 1'b0;
      w_z_b_nxt   = 1'b0;
    end else if (bus.en) begin
      w_hist_nxt = {r_hist[PAT_LEN-2:0], bus.w};
      if (r_state == ST_FILL) begin
        w_fill_nxt = r_fill + FILL_W'(1);
      end
      w_full      = (w_fill_nxt == FILL_FULL);
      w_state_nxt = w_full ? ST_TRACK : ST_FILL;
      w_match_a   = w_full && (w_hist_nxt == PAT_A);
      w_match_b   = w_full && (w_hist_nxt == PAT_B);
      w_z_a_nxt   = w_match_a;
      w_z_b_nxt   = w_match_b;
      w_inc       = w_match_a | w_match_b;
      if (!OVERLAP && w_inc) begin
        w_fill_nxt  = '0;
        w_state_nxt = ST_FILL;
      end
    end
  end

  logic [CNT_W-1:0] w_cnt;
  logic             w_sat;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.clr_cnt),
    .inc     (w_inc),
    .cnt     (w_cnt),
    .sat     (w_sat)
  );

  assign bus.z         = r_z;
  assign bus.z_a       = r_z_a;
  assign bus.z_b       = r_z_b;
  assign bus.match_cnt = w_cnt;
  assign bus.cnt_sat   = w_sat;
endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Scoreboard bench: four detector builds (overlap, non-overlap, zero pattern B,
// 2-bit counter) driven one at a time; a negedge monitor checks queued expectations.
module tb_moore_seq_detector_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rstn_v = '0;
  logic [3:0] en_v   = '0;
  logic [3:0] w_v    = '0;
  logic [3:0] clr_v  = '0;
  logic [3:0] za_v, zb_v, z_v, sat_v;
  logic [7:0] cnt_v [4];

  moore_seq_detector_param_if #(.CNT_W(8)) b0 ();
  moore_seq_detector_param_if #(.CNT_W(8)) b1 ();
  moore_seq_detector_param_if #(.CNT_W(8)) b2 ();
  moore_seq_detector_param_if #(.CNT_W(2)) b3 ();

  assign b0.en = en_v[0]; assign b0.w = w_v[0]; assign b0.clr_cnt = clr_v[0];
  assign b1.en = en_v[1]; assign b1.w = w_v[1]; assign b1.clr_cnt = clr_v[1];
  assign b2.en = en_v[2]; assign b2.w = w_v[2]; assign b2.clr_cnt = clr_v[2];
  assign b3.en = en_v[3]; assign b3.w = w_v[3]; assign b3.clr_cnt = clr_v[3];

  assign za_v  = {b3.z_a, b2.z_a, b1.z_a, b0.z_a};
  assign zb_v  = {b3.z_b, b2.z_b, b1.z_b, b0.z_b};
  assign z_v   = {b3.z, b2.z, b1.z, b0.z};
  assign sat_v = {b3.cnt_sat, b2.cnt_sat, b1.cnt_sat, b0.cnt_sat};
  assign cnt_v[0] = b0.match_cnt;
  assign cnt_v[1] = b1.match_cnt;
  assign cnt_v[2] = b2.match_cnt;
  assign cnt_v[3] = 8'(b3.match_cnt);

  moore_seq_detector_param #(.PAT_LEN(4), .PAT_A(4'b1111), .PAT_B(4'b1001), .OVERLAP(1'b1), .CNT_W(8))
    u0 (.clk(clk), .reset_n(rstn_v[0]), .bus(b0.slave));
  moore_seq_detector_param #(.PAT_LEN(4), .PAT_A(4'b1111), .PAT_B(4'b1001), .OVERLAP(1'b0), .CNT_W(8))
    u1 (.clk(clk), .reset_n(rstn_v[1]), .bus(b1.slave));
  moore_seq_detector_param #(.PAT_LEN(4), .PAT_A(4'b1111), .PAT_B(4'b0000), .OVERLAP(1'b1), .CNT_W(8))
    u2 (.clk(clk), .reset_n(rstn_v[2]), .bus(b2.slave));
  moore_seq_detector_param #(.PAT_LEN(4), .PAT_A(4'b1111), .PAT_B(4'b1001), .OVERLAP(1'b1), .CNT_W(2))
    u3 (.clk(clk), .reset_n(rstn_v[3]), .bus(b3.slave));

  typedef struct {
    int         d;
    string      tag;
    logic       za;
    logic       zb;
    logic [7:0] cnt;
    logic       sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input int d, input string what,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d %s: got %0h expected %0h", tag, d, what, act, exp);
    end
  endtask

  // Monitor: every queued expectation refers to the edge just before this negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, e.d, "z_a", 8'(za_v[e.d]), 8'(e.za));
      chk(e.tag, e.d, "z_b", 8'(zb_v[e.d]), 8'(e.zb));
      chk(e.tag, e.d, "z", 8'(z_v[e.d]), 8'(e.za | e.zb));
      chk(e.tag, e.d, "match_cnt", cnt_v[e.d], e.cnt);
      chk(e.tag, e.d, "cnt_sat", 8'(sat_v[e.d]), 8'(e.sat));
    end
  end

  task automatic step(input int d, input string tag, input logic rn, input logic en,
                      input logic wi, input logic clr, input logic eza, input logic ezb,
                      input logic [7:0] ec, input logic es);
    exp_t e;
    rstn_v[d] = rn; en_v[d] = en; w_v[d] = wi; clr_v[d] = clr;
    @(posedge clk);
    #1;
    e.d = d; e.tag = tag; e.za = eza; e.zb = ezb; e.cnt = ec; e.sat = es;
    exp_q.push_back(e);
    rstn_v[d] = 1'b1; en_v[d] = 1'b0; clr_v[d] = 1'b0;
  endtask

  task automatic bitin(input int d, input string tag, input logic wi,
                       input logic eza, input logic ezb, input logic [7:0] ec, input logic es);
    step(d, tag, 1'b1, 1'b1, wi, 1'b0, eza, ezb, ec, es);
  endtask

  task automatic rst(input int d, input string tag);
    step(d, tag, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    exp_t e;
    // Global reset check on all four builds.
    rstn_v = '0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      e.d = d; e.tag = "reset"; e.za = 0; e.zb = 0; e.cnt = 0; e.sat = 0;
      exp_q.push_back(e);
    end
    rstn_v = '1;

    // 1. zero pattern B: fill guard, then reset mid-stream discards history
    bitin(2, "fill_g1", 0, 0, 0, 0, 0);
    bitin(2, "fill_g2", 0, 0, 0, 0, 0);
    bitin(2, "fill_g3", 0, 0, 0, 0, 0);
    bitin(2, "fill_g4", 0, 0, 1, 1, 0);
    bitin(2, "fill_g5", 0, 0, 1, 2, 0);
    rst(2, "mid_rst");
    bitin(2, "post_rst", 0, 0, 0, 0, 0);

    // 2. overlap, six ones
    rst(0, "t2_rst");
    bitin(0, "ov1_b1", 1, 0, 0, 0, 0);
    bitin(0, "ov1_b2", 1, 0, 0, 0, 0);
    bitin(0, "ov1_b3", 1, 0, 0, 0, 0);
    bitin(0, "ov1_b4", 1, 1, 0, 1, 0);
    bitin(0, "ov1_b5", 1, 1, 0, 2, 0);
    bitin(0, "ov1_b6", 1, 1, 0, 3, 0);

    // 3. overlap, 1001001
    rst(0, "t3_rst");
    bitin(0, "pb_b1", 1, 0, 0, 0, 0);
    bitin(0, "pb_b2", 0, 0, 0, 0, 0);
    bitin(0, "pb_b3", 0, 0, 0, 0, 0);
    bitin(0, "pb_b4", 1, 0, 1, 1, 0);
    bitin(0, "pb_b5", 0, 0, 0, 1, 0);
    bitin(0, "pb_b6", 0, 0, 0, 1, 0);
    bitin(0, "pb_b7", 1, 0, 1, 2, 0);

    // 4. non-overlap, eight ones
    for (int i = 1; i <= 8; i++) begin
      logic hit;
      hit = (i == 4) || (i == 8);
      bitin(1, $sformatf("nov_b%0d", i), 1, hit, 0, (i >= 8) ? 8'd2 : (i >= 4) ? 8'd1 : 8'd0, 0);
    end

    // 5. enable gaps
    rst(0, "t5_rst");
    bitin(0, "gap_b1", 1, 0, 0, 0, 0);
    bitin(0, "gap_b2", 1, 0, 0, 0, 0);
    step(0, "gap_s1", 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, "gap_s2", 1, 0, 1, 0, 0, 0, 0, 0);
    step(0, "gap_s3", 1, 0, 0, 0, 0, 0, 0, 0);
    bitin(0, "gap_b3", 1, 0, 0, 0, 0);
    bitin(0, "gap_b4", 1, 1, 0, 1, 0);
    step(0, "gap_hold1", 1, 0, 0, 0, 1, 0, 1, 0);
    step(0, "gap_hold2", 1, 0, 1, 0, 1, 0, 1, 0);
    bitin(0, "gap_b5", 0, 0, 0, 1, 0);

    // 6. 2-bit counter saturation and clear-over-match
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] c;
      c = (i < 4) ? 8'd0 : (i - 3 > 3) ? 8'd3 : 8'(i - 3);
      bitin(3, $sformatf("sat_b%0d", i), 1, (i >= 4), 0, c, (c == 8'd3));
    end
    step(3, "clr_on_match", 1, 1, 1, 1, 1, 0, 0, 0);
    bitin(3, "after_clr", 1, 1, 0, 1, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
